// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the instruction-memory, redirect and decode handshake signals of the fetch stage
//   master : fetch_sequencer side (drives imem_rd/imem_addr, out_* and fetch_count)
//   slave  : environment side (drives imem_rdata, redirect/redirect_pc, out_ready)
interface fetch_sequencer_if;
    logic        imem_rd;
    logic [27:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic [31:0] fetch_count;
    modport master (
        output imem_rd, imem_addr, out_valid, out_instr, out_pc, out_next_pc, fetch_count,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  imem_rd, imem_addr, out_valid, out_instr, out_pc, out_next_pc, fetch_count,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, reads four bytes from a byte-wide imem and hands a big-endian 32-bit instruction to decode
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_sequencer_if.master (imem read port, redirect, decode valid/ready, fetch_count)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        rd_q, rd_d;
    logic [1:0]  lane;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        asm_d   = asm_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        // byte returned this cycle belongs to the read issued at cnt-1; lane 0 is the MSB
        lane    = cnt_q[1:0] - 2'd1;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = 3'd0;
                asm_d   = 32'd0;
            end
            FETCH: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) asm_d[{~lane, 3'b111} -: 8] = bus.imem_rdata;
                if (cnt_q == 3'd4) state_d = VALID;
            end
            VALID: if (bus.out_ready) begin
                pc_d    = pc_q + 32'd4;
                count_d = count_q + 32'd1;
                state_d = FETCH;
                cnt_d   = 3'd0;
                asm_d   = 32'd0;
            end
            default: state_d = IDLE;
        endcase
        // redirect overrides the sequential PC but leaves a coincident handshake counted
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc & ~32'd3;
            state_d = FETCH;
            cnt_d   = 3'd0;
            asm_d   = 32'd0;
        end
        valid_d = state_d == VALID;
        rd_d    = (state_d == FETCH) && (cnt_d < 3'd4);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            asm_q   <= 32'd0;
            count_q <= 32'd0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            asm_q   <= asm_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end
    assign bus.imem_rd     = rd_q;
    assign bus.imem_addr   = pc_q[27:0] + {25'd0, cnt_q};
    assign bus.out_valid   = valid_q;
    assign bus.out_instr   = asm_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_next_pc = pc_q + 32'd4;
    assign bus.fetch_count = count_q;
endmodule
